// File: rtl/rx_frame_aligner_pkg.sv
// Shared constants and types for the receive frame aligner.
package rx_frame_aligner_pkg;

   localparam int PKT_W        = 8;
   localparam int SYNC_W       = 8;
   localparam logic [SYNC_W-1:0] SYNC_WORD = 8'hA5;
   localparam int PAYLOAD_PKTS = 4;
   localparam int LOCK_CNT     = 3;
   localparam int UNLOCK_CNT   = 2;

   localparam int PAYLOAD_BITS = PAYLOAD_PKTS * PKT_W;
   localparam int FRAME_LEN    = SYNC_W + PAYLOAD_BITS;
   localparam int POS_W        = $clog2(FRAME_LEN);
   localparam int FILL_W       = $clog2(SYNC_W);
   // History depth: enough past bits to form either a sync or a packet word with the live bit.
   localparam int SR_W         = ((SYNC_W > PKT_W) ? SYNC_W : PKT_W) - 1;

   typedef logic [PKT_W-1:0] packet_t;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } rx_state_t;

   // True when the bit at frame index pos is the last bit of a payload packet.
   function automatic logic is_pkt_end(input logic [POS_W-1:0] pos);
      return (int'(pos) < PAYLOAD_BITS) && ((int'(pos) % PKT_W) == PKT_W - 1);
   endfunction

endpackage

// File: rtl/rx_lock_fsm.sv
// Alignment state machine: hunt, verify over consecutive frames, hold lock until repeated misses.
module rx_lock_fsm
   import rx_frame_aligner_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      boundary,
   input  logic      match,
   output rx_state_t state,
   output logic      locked,
   output logic      frame_start,
   output logic      sync_err
);

   localparam int MCNT_W = $clog2(LOCK_CNT + 1);
   localparam int XCNT_W = $clog2(UNLOCK_CNT + 1);

   rx_state_t         state_q, state_d;
   logic [MCNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [XCNT_W-1:0] miss_cnt_q, miss_cnt_d;
   logic              frame_start_q, frame_start_d;
   logic              sync_err_q, sync_err_d;

   // State, counters and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= HUNT;
         match_cnt_q   <= '0;
         miss_cnt_q    <= '0;
         frame_start_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         match_cnt_q   <= match_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         frame_start_q <= frame_start_d;
         sync_err_q    <= sync_err_d;
      end
   end

   // Next state: decisions are only taken on a sync boundary strobe.
   always_comb begin
      state_d       = state_q;
      match_cnt_d   = match_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      frame_start_d = 1'b0;
      sync_err_d    = 1'b0;
      case (state_q)
         HUNT: begin
            if (boundary && match) begin
               match_cnt_d = MCNT_W'(1);
               if (LOCK_CNT == 1) begin
                  state_d       = LOCKED;
                  frame_start_d = 1'b1;
                  miss_cnt_d    = '0;
               end else begin
                  state_d = VERIFY;
               end
            end
         end
         VERIFY: begin
            if (boundary) begin
               if (match) begin
                  match_cnt_d = match_cnt_q + 1'b1;
                  if (match_cnt_q == MCNT_W'(LOCK_CNT - 1)) begin
                     state_d       = LOCKED;
                     frame_start_d = 1'b1;
                     miss_cnt_d    = '0;
                  end
               end else begin
                  // The missing bit is already in the history, so hunting restarts without refill.
                  state_d     = HUNT;
                  match_cnt_d = '0;
               end
            end
         end
         LOCKED: begin
            if (boundary) begin
               if (match) begin
                  frame_start_d = 1'b1;
                  miss_cnt_d    = '0;
               end else begin
                  sync_err_d = 1'b1;
                  if (miss_cnt_q == XCNT_W'(UNLOCK_CNT - 1)) begin
                     state_d     = HUNT;
                     miss_cnt_d  = '0;
                     match_cnt_d = '0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   assign state       = state_q;
   assign locked      = (state_q == LOCKED);
   assign frame_start = frame_start_q;
   assign sync_err    = sync_err_q;

endmodule

// File: rtl/rx_frame_aligner.sv
// Serial receive frame aligner: finds the sync word, confirms lock and emits aligned payload packets.
module rx_frame_aligner
   import rx_frame_aligner_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    din,
   output packet_t pkt_data,
   output logic    pkt_valid,
   output logic    frame_start,
   output logic    locked,
   output logic    sync_err
);

   logic [SR_W-1:0]   sr_q, sr_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   packet_t           pkt_data_q, pkt_data_d;
   logic              pkt_valid_q, pkt_valid_d;

   logic [SYNC_W-1:0] sync_cand;
   packet_t           pkt_cand;
   logic              fill_done;
   logic              at_frame_end;
   logic              boundary;
   logic              match;
   rx_state_t         state;

   rx_lock_fsm u_lock_fsm (
      .clk         (clk),
      .rst         (rst),
      .boundary    (boundary),
      .match       (match),
      .state       (state),
      .locked      (locked),
      .frame_start (frame_start),
      .sync_err    (sync_err)
   );

   // Bit history, frame position, fill progress and packet output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q        <= '0;
         pos_q       <= '0;
         fill_q      <= '0;
         pkt_data_q  <= '0;
         pkt_valid_q <= 1'b0;
      end else begin
         sr_q        <= sr_d;
         pos_q       <= pos_d;
         fill_q      <= fill_d;
         pkt_data_q  <= pkt_data_d;
         pkt_valid_q <= pkt_valid_d;
      end
   end

   // Candidate words include the live bit; in HUNT every cycle after fill is a potential boundary.
   always_comb begin
      sync_cand    = {sr_q[SYNC_W-2:0], din};
      pkt_cand     = {sr_q[PKT_W-2:0], din};
      sr_d         = {sr_q[SR_W-2:0], din};
      fill_done    = (fill_q == FILL_W'(SYNC_W - 1));
      fill_d       = fill_done ? fill_q : fill_q + 1'b1;
      match        = (sync_cand == SYNC_WORD);
      at_frame_end = (pos_q == POS_W'(FRAME_LEN - 1));
      boundary     = (state == HUNT) ? fill_done : at_frame_end;

      if (state == HUNT || at_frame_end) begin
         pos_d = '0;
      end else begin
         pos_d = pos_q + 1'b1;
      end

      pkt_data_d  = pkt_data_q;
      pkt_valid_d = 1'b0;
      if (state == LOCKED && is_pkt_end(pos_q)) begin
         pkt_data_d  = pkt_cand;
         pkt_valid_d = 1'b1;
      end
   end

   assign pkt_data  = pkt_data_q;
   assign pkt_valid = pkt_valid_q;

endmodule

// File: tb/tb_rx_frame_aligner.sv
// Directed bench for rx_frame_aligner: hunt, lock, sync errors, unlock, relock and reset.
module tb_rx_frame_aligner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic [7:0] pkt_data;
   logic       pkt_valid;
   logic       frame_start;
   logic       locked;
   logic       sync_err;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         fs_cnt = 0;
   int         se_cnt = 0;
   logic [7:0] pkt_q[$];
   int         pkt_cyc[$];

   rx_frame_aligner dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .pkt_data    (pkt_data),
      .pkt_valid   (pkt_valid),
      .frame_start (frame_start),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   // Drive one bit, clock it in, then log any pulses it produced.
   task automatic send_bit(input logic b);
      din = b;
      @(posedge clk);
      #1;
      cyc++;
      if (pkt_valid === 1'b1) begin
         pkt_q.push_back(pkt_data);
         pkt_cyc.push_back(cyc);
         $display("pkt 0x%02h at cycle %0d", pkt_data, cyc);
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (sync_err === 1'b1) se_cnt++;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   // A frame on the line is its payload followed by its sync field.
   task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3,
                             input logic [7:0] s);
      send_byte(p0);
      send_byte(p1);
      send_byte(p2);
      send_byte(p3);
      send_byte(s);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      din = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({pkt_data, pkt_valid, frame_start, locked, sync_err} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_outputs got=%h want=000", {pkt_data, pkt_valid, frame_start, locked, sync_err});
      end
   endtask

   task automatic test_no_sync();
      do_reset();
      pkt_q.delete();
      for (int i = 0; i < 50; i++) send_bit((i % 8) < 4);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL nosync_locked got=%b want=0", locked); end
      n_cmp++;
      if (pkt_q.size() != 0) begin n_bad++; $display("FAIL nosync_pkts got=%0d want=0", pkt_q.size()); end
   endtask

   task automatic test_lock();
      int t0;
      do_reset();
      pkt_q.delete();
      pkt_cyc.delete();
      fs_cnt = 0;
      send_byte(8'hA5);
      send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hA5);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early got=%b want=0", locked); end
      send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hA5);
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_third got=%b want=1", locked); end
      n_cmp++;
      if (frame_start !== 1'b1 || fs_cnt != 1) begin
         n_bad++; $display("FAIL lock_frame_start got=%b/%0d want=1/1", frame_start, fs_cnt);
      end
      n_cmp++;
      if (pkt_q.size() != 0) begin n_bad++; $display("FAIL lock_no_early_pkts got=%0d want=0", pkt_q.size()); end
      t0 = cyc;
      send_frame(8'h55, 8'h66, 8'h77, 8'h88, 8'hA5);
      n_cmp++;
      if (pkt_q.size() != 4) begin n_bad++; $display("FAIL lock_pkt_count got=%0d want=4", pkt_q.size()); end
      for (int i = 0; i < 4; i++) begin
         logic [7:0] exp_d;
         exp_d = 8'h55 + 8'(i * 8'h11);
         n_cmp++;
         if (pkt_q[i] !== exp_d) begin n_bad++; $display("FAIL lock_pkt_data%0d got=%h want=%h", i, pkt_q[i], exp_d); end
         n_cmp++;
         if (pkt_cyc[i] != t0 + 8 * (i + 1)) begin
            n_bad++; $display("FAIL lock_pkt_time%0d got=%0d want=%0d", i, pkt_cyc[i], t0 + 8 * (i + 1));
         end
      end
      n_cmp++;
      if (frame_start !== 1'b1) begin n_bad++; $display("FAIL lock_next_sync got=%b want=1", frame_start); end
   endtask

   task automatic test_single_miss();
      int se0;
      pkt_q.delete();
      se0 = se_cnt;
      send_frame(8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hA4);
      n_cmp++;
      if (sync_err !== 1'b1 || locked !== 1'b1) begin
         n_bad++; $display("FAIL miss1_err_locked got=%b%b want=11", sync_err, locked);
      end
      send_frame(8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hA5);
      n_cmp++;
      if (se_cnt - se0 != 1) begin n_bad++; $display("FAIL miss1_pulses got=%0d want=1", se_cnt - se0); end
      n_cmp++;
      if (frame_start !== 1'b1) begin n_bad++; $display("FAIL miss1_recover got=%b want=1", frame_start); end
      n_cmp++;
      if (pkt_q.size() != 8 || pkt_q[4] !== 8'hD1 || pkt_q[7] !== 8'hD4) begin
         n_bad++; $display("FAIL miss1_payload got=%0d/%h/%h want=8/d1/d4", pkt_q.size(), pkt_q[4], pkt_q[7]);
      end
   endtask

   task automatic test_unlock_relock();
      pkt_q.delete();
      send_frame(8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'h00);
      n_cmp++;
      if (sync_err !== 1'b1 || locked !== 1'b1) begin
         n_bad++; $display("FAIL unlock_first got=%b%b want=11", sync_err, locked);
      end
      send_frame(8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'h00);
      n_cmp++;
      if (sync_err !== 1'b1 || locked !== 1'b0) begin
         n_bad++; $display("FAIL unlock_second got=%b%b want=10", sync_err, locked);
      end
      n_cmp++;
      if (pkt_q.size() != 8) begin n_bad++; $display("FAIL unlock_payloads got=%0d want=8", pkt_q.size()); end
      pkt_q.delete();
      send_byte(8'hA5);
      send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'hA5);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL relock_early got=%b want=0", locked); end
      send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'hA5);
      n_cmp++;
      if (locked !== 1'b1 || pkt_q.size() != 0) begin
         n_bad++; $display("FAIL relock got=%b/%0d want=1/0", locked, pkt_q.size());
      end
      send_frame(8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'hA5);
      n_cmp++;
      if (pkt_q.size() != 4 || pkt_q[0] !== 8'h5A) begin
         n_bad++; $display("FAIL relock_payload got=%0d/%h want=4/5a", pkt_q.size(), pkt_q[0]);
      end
   endtask

   task automatic test_verify_fail();
      int fs0;
      do_reset();
      fs0 = fs_cnt;
      send_byte(8'hA5);
      send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
      n_cmp++;
      if (locked !== 1'b0 || fs_cnt != fs0) begin
         n_bad++; $display("FAIL verify_miss got=%b/%0d want=0/%0d", locked, fs_cnt, fs0);
      end
      send_byte(8'hA5);
      send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'hA5);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL verify_two_fresh got=%b want=0", locked); end
      send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'hA5);
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL verify_three_fresh got=%b want=1", locked); end
   endtask

   task automatic test_mid_reset();
      logic [7:0] part;
      part = 8'h66;
      pkt_q.delete();
      send_byte(8'h55);
      for (int i = 7; i >= 4; i--) send_bit(part[i]);
      n_cmp++;
      if (pkt_q.size() != 1 || pkt_q[0] !== 8'h55) begin
         n_bad++; $display("FAIL midrst_pre got=%0d/%h want=1/55", pkt_q.size(), pkt_q[0]);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({pkt_data, pkt_valid, frame_start, locked, sync_err} !== 12'h000) begin
         n_bad++; $display("FAIL midrst_outputs got=%h want=000", {pkt_data, pkt_valid, frame_start, locked, sync_err});
      end
      rst = 1'b0;
      for (int i = 3; i >= 0; i--) send_bit(part[i]);
      send_byte(8'h00);
      send_byte(8'h00);
      n_cmp++;
      if (pkt_q.size() != 1 || locked !== 1'b0) begin
         n_bad++; $display("FAIL midrst_after got=%0d/%b want=1/0", pkt_q.size(), locked);
      end
   endtask

   initial begin
      test_reset();
      test_no_sync();
      test_lock();
      test_single_miss();
      test_unlock_relock();
      test_verify_fail();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
